series_unit_arbiter: RTL and testbench
======================================

Name: series_unit_arbiter

Overview:
- Shares one series-evaluation unit between two requesters, round-robin.
- The unit is the controller-plus-datapath pair with a start/ready handshake: ready is high while idle, start must pulse then fall, and ready returns high when the result is valid.
- The arbiter latches the winner's operand, sequences the unit's start/ready handshake, captures the result and returns it with a one-cycle done pulse.
- A watchdog counter aborts on a hung unit.

Parameters:
- XW, 8, operand width (x) driven to the unit.
- RW, 16, result width returned by the unit.
- TMO, 255, maximum cycles spent waiting on the unit before abort; counter width is clog2(TMO+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0  input  1  requester 0 request level.
- x0  input  XW  requester 0 operand.
- req1  input  1  requester 1 request level.
- x1  input  XW  requester 1 operand.
- unit_ready  input  1  unit idle/result-valid flag.
- unit_result  input  RW  unit result, valid while unit_ready=1 after a run.
- unit_start  output  1  start pulse to the unit.
- unit_x  output  XW  operand to the unit, held stable START..RESP.
- gnt0  output  1  requester 0 owns the unit.
- gnt1  output  1  requester 1 owns the unit.
- done0  output  1  one-cycle completion pulse to requester 0.
- done1  output  1  one-cycle completion pulse to requester 1.
- result  output  RW  registered result, held until the next capture.
- err  output  1  pulses together with done when the run aborted on timeout.

Behaviour:
- Reset:
  - State IDLE; all outputs are 0 (unit_start, unit_x, gnt0/1, done0/1, result, err).
  - Priority pointer is 0, so req0 wins the first tie.
  - Watchdog counter is 0.
  - Reset mid-run returns to IDLE immediately with no done pulse; resetting the unit is the top level's job.
- Requester contract:
  - Hold req high with stable x until done.
  - req still high in the cycle after done is treated as a new request.
  - Dropping req mid-run is ignored; the run completes and done still pulses.
- State machine (Moore outputs, registered state):
  - IDLE: leave only if (req0|req1) && unit_ready.
    - Winner: the sole requester; on a tie, the requester selected by the pointer.
    - Latch the winner's x into the operand register and record the winner id; go to START.
    - If unit_ready=0, stay in IDLE and grant nothing.
  - START, exactly 1 cycle: unit_start=1; gnt of the winner=1; go to WAIT_BUSY.
  - WAIT_BUSY: unit_start=0.
    - unit_ready=0 → WAIT_DONE.
    - Otherwise increment the watchdog.
  - WAIT_DONE: on unit_ready=1, capture unit_result into result at that clock edge and go to RESP.
  - Watchdog:
    - Runs in WAIT_BUSY and WAIT_DONE; it is not cleared between the two states.
    - It is cleared on entry to START.
    - When the count reaches TMO → RESP with the abort flag set; result is not updated.
  - RESP, 1 cycle: done of the winner=1; err=abort flag.
    - The pointer is set to the non-winner.
    - Clear the abort flag; go to IDLE.
- gnt is high from START through RESP inclusive; gnt0 and gnt1 are never high together.
- unit_x always reflects the operand register.
- Minimum request-to-done latency: 4 + N cycles, where N is the number of cycles unit_ready stays low. The sequence is IDLE sample → START → WAIT_BUSY → WAIT_DONE×N → RESP.
- Back-to-back operation: from RESP, the next grant decision is made in IDLE on the following cycle. There is no bypass.
- No arithmetic beyond the watchdog increment, which saturates at TMO.

Test Plan:
1. Single request, unit model with ready low for 8 cycles: req0=1, x0=8'h05, unit returns 16'h1234.
   - unit_start is high exactly 1 cycle.
   - unit_x=8'h05 throughout.
   - done0 pulses once, 12 cycles after req0 is sampled.
   - result=16'h1234; err=0; gnt1 never asserts.
2. Simultaneous req0 and req1 held continuously, x0=8'h01, x1=8'h02.
   - Grants alternate 0,1,0,1.
   - unit_x matches the owner's operand each run.
   - done0 and done1 alternate; each result matches the model for its operand.
3. req1 raised while unit_ready=0 in IDLE for 5 cycles: no unit_start and no gnt until ready rises; the START cycle follows 1 cycle after ready is sampled high.
4. Hung unit with ready held low forever, TMO=16: done0 and err pulse together after the watchdog expires; result keeps its previous value; the next request proceeds normally once the unit model recovers.
5. rst asserted during WAIT_DONE: all outputs go to 0 asynchronously with no done pulse; after release, a pending req1 with the pointer reset to 0 and req0 low is granted normally.
6. req0 dropped during WAIT_BUSY: the run completes, done0 pulses, and no new request is started for requester 0.

Source files
------------

// File: rtl/series_unit_arbiter.sv
// Round-robin arbiter sharing one series-evaluation unit between two requesters.
// Sequences the unit's start/ready handshake and aborts a hung run with a watchdog.
module series_unit_arbiter #(
    parameter int XW  = 8,
    parameter int RW  = 16,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [XW-1:0] x0,
    input  logic          req1,
    input  logic [XW-1:0] x1,
    input  logic          unit_ready,
    input  logic [RW-1:0] unit_result,
    output logic          unit_start,
    output logic [XW-1:0] unit_x,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [RW-1:0] result,
    output logic          err
);

    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_C = CW'(TMO);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t        state;
    logic          ptr;
    logic          owner;
    logic          pick;
    logic [CW-1:0] wdog;
    logic [XW-1:0] x_reg;

    assign unit_x = x_reg;

    // Sole requester wins; on a tie the priority pointer decides (1 = requester 1).
    always_comb begin
        pick = (req0 && req1) ? ptr : req1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            wdog       <= '0;
            x_reg      <= '0;
            unit_start <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            result     <= '0;
            err        <= 1'b0;
        end else begin
            unit_start <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if ((req0 || req1) && unit_ready) begin
                        owner      <= pick;
                        x_reg      <= pick ? x1 : x0;
                        gnt0       <= !pick;
                        gnt1       <= pick;
                        unit_start <= 1'b1;
                        wdog       <= '0;
                        state      <= START;
                    end
                end
                START: begin
                    state <= WAIT_BUSY;
                end
                // The watchdog keeps counting across WAIT_BUSY and WAIT_DONE.
                WAIT_BUSY: begin
                    if (!unit_ready) begin
                        state <= WAIT_DONE;
                    end else if (wdog == TMO_C) begin
                        done0 <= !owner;
                        done1 <= owner;
                        err   <= 1'b1;
                        state <= RESP;
                    end else begin
                        wdog <= wdog + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (unit_ready) begin
                        result <= unit_result;
                        done0  <= !owner;
                        done1  <= owner;
                        state  <= RESP;
                    end else if (wdog == TMO_C) begin
                        done0 <= !owner;
                        done1 <= owner;
                        err   <= 1'b1;
                        state <= RESP;
                    end else begin
                        wdog <= wdog + CW'(1);
                    end
                end
                RESP: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    ptr   <= !owner;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_series_unit_arbiter.sv
// Self-checking bench for series_unit_arbiter: directed scenarios plus randomized
// transactions against a transaction-level round-robin model and a behavioural unit.
module tb_series_unit_arbiter;

    localparam int XW  = 8;
    localparam int RW  = 16;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [XW-1:0] x0, x1;
    logic          unit_ready;
    logic [RW-1:0] unit_result;
    logic          unit_start;
    logic [XW-1:0] unit_x;
    logic          gnt0, gnt1, done0, done1;
    logic [RW-1:0] result;
    logic          err;

    int   checks   = 0;
    int   failures = 0;
    int   lat      = 1;
    logic force_low = 1'b0;
    logic exp_ptr   = 1'b0;

    logic          m_ready, m_busy;
    int            m_cnt;
    logic [XW-1:0] m_x;
    logic [RW-1:0] m_res;

    int            cyc, st;
    logic          d0, d1, e, g0, g1, bo, uxb;
    logic [XW-1:0] ux;

    series_unit_arbiter #(.XW(XW), .RW(RW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .x0(x0), .req1(req1), .x1(x1),
        .unit_ready(unit_ready), .unit_result(unit_result),
        .unit_start(unit_start), .unit_x(unit_x),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] unit_fn(input logic [XW-1:0] x);
        return 16'h1234 + ({8'h00, x} - 16'h0005) * 16'h0101;
    endfunction

    // Behavioural unit: ready drops on start and stays low for lat cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            m_x     <= '0;
            m_res   <= '0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_ready <= 1'b1;
                m_busy  <= 1'b0;
                m_res   <= unit_fn(m_x);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (unit_start) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b1;
            m_cnt   <= lat;
            m_x     <= unit_x;
        end
    end

    assign unit_ready  = m_ready && !force_low;
    assign unit_result = m_res;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [XW-1:0] a0,
                                 input logic r1, input logic [XW-1:0] a1);
        req0 = r0;
        x0   = a0;
        req1 = r1;
        x1   = a1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        force_low = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0);
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        exp_ptr = 1'b0;
        @(negedge clk);
    endtask

    // Observes the run cycle by cycle until a done pulse or the bound expires.
    task automatic run_txn(input int c0, input int bound);
        logic got;
        got = 1'b0;
        cyc = c0;
        st  = 0;
        g0 = 1'b0; g1 = 1'b0; bo = 1'b0; uxb = 1'b0;
        d0 = 1'b0; d1 = 1'b0; e = 1'b0;
        ux = unit_x;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (unit_start) begin
                st++;
                ux = unit_x;
            end
            if (gnt0) g0 = 1'b1;
            if (gnt1) g1 = 1'b1;
            if (gnt0 && gnt1) bo = 1'b1;
            if ((gnt0 || gnt1) && st > 0 && unit_x !== ux) uxb = 1'b1;
            if (done0 || done1) begin
                got = 1'b1;
                d0  = done0;
                d1  = done1;
                e   = err;
            end
        end
        checkOutput("done_seen", 32'(got), 32'd1);
    endtask

    // One complete transaction predicted by the round-robin model.
    task automatic serve(input logic r0, input logic [XW-1:0] a0,
                         input logic r1, input logic [XW-1:0] a1, input int l);
        logic          owner;
        logic [XW-1:0] ex;
        lat = l;
        applyStimulus(r0, a0, r1, a1);
        owner = (r0 && r1) ? exp_ptr : r1;
        ex    = owner ? a1 : a0;
        run_txn(1, 80);
        checkOutput("latency", 32'(cyc), 32'(l + 4));
        checkOutput("done0", 32'(d0), 32'(!owner));
        checkOutput("done1", 32'(d1), 32'(owner));
        checkOutput("err", 32'(e), 32'd0);
        checkOutput("start_count", 32'(st), 32'd1);
        checkOutput("own_gnt", 32'(owner ? g1 : g0), 32'd1);
        checkOutput("other_gnt", 32'(owner ? g0 : g1), 32'd0);
        checkOutput("gnt_overlap", 32'(bo), 32'd0);
        checkOutput("unit_x", 32'(ux), 32'(ex));
        checkOutput("unit_x_stable", 32'(uxb), 32'd0);
        checkOutput("result", 32'(result), 32'(unit_fn(ex)));
        exp_ptr = !owner;
        @(negedge clk);
        checkOutput("done_width", 32'({done0, done1}), 32'd0);
        checkOutput("gnt_release", 32'({gnt0, gnt1}), 32'd0);
    endtask

    initial begin
        logic          flag_a, flag_b;
        logic [RW-1:0] prev;
        logic [1:0]    pat;

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("rst_ctrl", 32'({unit_start, gnt0, gnt1, done0, done1, err}), 32'd0);
        checkOutput("rst_unit_x", 32'(unit_x), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);

        $display("[TB] single request");
        do_reset();
        serve(1'b1, 8'h05, 1'b0, 8'h00, 8);
        checkOutput("result_1234", 32'(result), 32'h1234);

        $display("[TB] simultaneous requests");
        do_reset();
        for (int k = 0; k < 4; k++) serve(1'b1, 8'h01, 1'b1, 8'h02, 3 + k);

        $display("[TB] unit not ready in idle");
        do_reset();
        force_low = 1'b1;
        lat = 3;
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h3C);
        flag_a = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (unit_start || gnt0 || gnt1) flag_a = 1'b1;
        end
        checkOutput("no_grant_busy", 32'(flag_a), 32'd0);
        force_low = 1'b0;
        @(negedge clk);
        checkOutput("late_start", 32'({unit_start, gnt1}), 32'd3);
        run_txn(2, 40);
        checkOutput("late_done1", 32'(d1), 32'd1);
        checkOutput("late_result", 32'(result), 32'(unit_fn(8'h3C)));
        applyStimulus(1'b0, '0, 1'b0, '0);

        $display("[TB] hung unit");
        do_reset();
        serve(1'b1, 8'h21, 1'b0, 8'h00, 3);
        prev = result;
        lat = 3;
        applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("hung_start", 32'(unit_start), 32'd1);
        force_low = 1'b1;
        run_txn(2, 60);
        checkOutput("hung_done0", 32'(d0), 32'd1);
        checkOutput("hung_err", 32'(e), 32'd1);
        checkOutput("hung_result", 32'(result), 32'(prev));
        checkOutput("tmo_window", 32'(cyc >= TMO + 2 && cyc <= TMO + 8), 32'd1);
        exp_ptr = 1'b1;
        force_low = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        checkOutput("hung_err_width", 32'(err), 32'd0);
        serve(1'b1, 8'h66, 1'b0, 8'h00, 4);

        $display("[TB] reset mid-run");
        do_reset();
        lat = 10;
        applyStimulus(1'b1, 8'h11, 1'b0, 8'h00);
        repeat (5) @(negedge clk);
        checkOutput("pre_rst_gnt0", 32'(gnt0), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_async", 32'({gnt0, gnt1, done0, done1, unit_start, err}), 32'd0);
        checkOutput("rst_async_x", 32'(unit_x), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h22);
        flag_a = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done0 || done1) flag_a = 1'b1;
        end
        checkOutput("rst_no_done", 32'(flag_a), 32'd0);
        rst = 1'b0;
        exp_ptr = 1'b0;
        serve(1'b0, 8'h00, 1'b1, 8'h22, 5);

        $display("[TB] request dropped mid-run");
        do_reset();
        lat = 6;
        applyStimulus(1'b1, 8'h44, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        run_txn(3, 40);
        checkOutput("drop_done0", 32'(d0), 32'd1);
        checkOutput("drop_result", 32'(result), 32'(unit_fn(8'h44)));
        flag_b = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (unit_start || gnt0) flag_b = 1'b1;
        end
        checkOutput("drop_no_restart", 32'(flag_b), 32'd0);

        $display("[TB] randomized transactions");
        do_reset();
        for (int k = 0; k < 16; k++) begin
            pat = 2'($urandom_range(1, 3));
            serve(pat[0], 8'($urandom), pat[1], 8'($urandom), $urandom_range(1, 12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
